// File: rtl/kernel_rtc_ctrl.sv
// rtl/kernel_rtc_ctrl.sv - DS1302-style 3-wire RTC serial engine with Avalon-MM register access
module kernel_rtc_ctrl #(
  parameter logic [7:0] DIV_RESET = 8'd49
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        rtc_ce,
  output logic        rtc_sclk,
  inout  wire         rtc_io
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_CMD_LO = 3'd2,
    S_CMD_HI = 3'd3,
    S_DAT_LO = 3'd4,
    S_DAT_HI = 3'd5,
    S_HOLD   = 3'd6,
    S_RECOV  = 3'd7
  } state_t;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_CMD    = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_DIV    = 2'd3;

  // Sequencer state and counters
  state_t     state_q, state_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] div_lat_q, div_lat_d;

  // Register file
  logic [7:0] tx_q;
  logic [7:0] cmd_q;
  logic [7:0] div_q;
  logic [7:0] rx_q;
  logic [7:0] rx_sh_q;
  logic       done_q;
  logic [31:0] rdata_q, rdata_d;

  // Registered pin drivers
  logic ce_q, ce_d;
  logic sclk_q, sclk_d;
  logic oe_q, oe_d;
  logic io_q, io_d;

  // Bus decode
  logic wr_en;
  logic rd_en;
  logic busy;
  logic start;
  logic last;
  logic finish;
  logic sample;
  logic wdata_unused;

  assign wr_en        = chipselect & ~write_n;
  assign rd_en        = chipselect & ~read_n;
  assign busy         = (state_q != S_IDLE);
  assign start        = wr_en && (address == A_CMD) && !busy;
  assign last         = (hcnt_q == div_lat_q);
  assign finish       = (state_q == S_RECOV) && last;
  // Receive bits are captured at the very end of the low half, just before SCLK rises
  assign sample       = (state_q == S_DAT_LO) && last && cmd_q[0];
  assign wdata_unused = ^writedata[31:8];

  // State register: sequencer state, half-period counter, bit index, latched divider
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hcnt_q    <= 8'd0;
      bit_q     <= 3'd0;
      div_lat_q <= DIV_RESET;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      bit_q     <= bit_d;
      div_lat_q <= div_lat_d;
    end
  end

  // Next-state logic: every non-idle state lasts exactly DIV+1 cycles
  always_comb begin
    state_d   = state_q;
    hcnt_d    = (state_q == S_IDLE || last) ? 8'd0 : hcnt_q + 8'd1;
    bit_d     = bit_q;
    div_lat_d = div_lat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SETUP;
          bit_d     = 3'd0;
          div_lat_d = div_q;
        end
      end
      S_SETUP: begin
        if (last) begin
          state_d = S_CMD_LO;
          bit_d   = 3'd0;
        end
      end
      S_CMD_LO: begin
        if (last) state_d = S_CMD_HI;
      end
      S_CMD_HI: begin
        if (last) begin
          // bit index wraps 7 -> 0 naturally on the way into the data phase
          bit_d   = bit_q + 3'd1;
          state_d = (bit_q == 3'd7) ? S_DAT_LO : S_CMD_LO;
        end
      end
      S_DAT_LO: begin
        if (last) state_d = S_DAT_HI;
      end
      S_DAT_HI: begin
        if (last) begin
          bit_d   = bit_q + 3'd1;
          state_d = (bit_q == 3'd7) ? S_HOLD : S_DAT_LO;
        end
      end
      S_HOLD: begin
        if (last) state_d = S_RECOV;
      end
      S_RECOV: begin
        if (last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: pin values for the upcoming state, so pins change on the same edge as the state
  always_comb begin
    ce_d   = 1'b0;
    sclk_d = 1'b0;
    oe_d   = 1'b0;
    io_d   = 1'b0;
    case (state_d)
      S_IDLE: begin
        ce_d = 1'b0;
      end
      S_SETUP: begin
        ce_d = 1'b1;
      end
      S_CMD_LO: begin
        ce_d = 1'b1;
        oe_d = 1'b1;
        io_d = cmd_q[bit_d];
      end
      S_CMD_HI: begin
        ce_d   = 1'b1;
        sclk_d = 1'b1;
        oe_d   = 1'b1;
        io_d   = io_q;
      end
      S_DAT_LO: begin
        ce_d = 1'b1;
        oe_d = ~cmd_q[0];
        io_d = cmd_q[0] ? 1'b0 : tx_q[bit_d];
      end
      S_DAT_HI: begin
        ce_d   = 1'b1;
        sclk_d = 1'b1;
        oe_d   = ~cmd_q[0];
        io_d   = cmd_q[0] ? 1'b0 : io_q;
      end
      S_HOLD: begin
        ce_d = 1'b1;
      end
      S_RECOV: begin
        ce_d = 1'b0;
      end
      default: begin
        ce_d = 1'b0;
      end
    endcase
  end

  // Pin registers: all RTC pins come straight from flops
  always_ff @(posedge clk) begin
    if (reset) begin
      ce_q   <= 1'b0;
      sclk_q <= 1'b0;
      oe_q   <= 1'b0;
      io_q   <= 1'b0;
    end else begin
      ce_q   <= ce_d;
      sclk_q <= sclk_d;
      oe_q   <= oe_d;
      io_q   <= io_d;
    end
  end

  assign rtc_ce   = ce_q;
  assign rtc_sclk = sclk_q;
  assign rtc_io   = oe_q ? io_q : 1'bz;

  // Read mux: sampled every cycle regardless of chipselect
  always_comb begin
    rdata_d = 32'd0;
    case (address)
      A_DATA:   rdata_d = {24'd0, rx_q};
      A_CMD:    rdata_d = {24'd0, cmd_q};
      A_STATUS: rdata_d = {30'd0, done_q, busy};
      A_DIV:    rdata_d = {24'd0, div_q};
      default:  rdata_d = 32'd0;
    endcase
  end

  // Register file: host writes are only accepted while idle; DONE set beats a coincident clear
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_q    <= 8'd0;
      cmd_q   <= 8'd0;
      div_q   <= DIV_RESET;
      rx_q    <= 8'd0;
      rx_sh_q <= 8'd0;
      done_q  <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      rdata_q <= rdata_d;
      if (wr_en && !busy) begin
        case (address)
          A_DATA:  tx_q  <= writedata[7:0];
          A_CMD:   cmd_q <= writedata[7:0];
          A_DIV:   div_q <= writedata[7:0];
          default: ;
        endcase
      end
      if (sample) rx_sh_q[bit_q] <= rtc_io;
      if (finish && cmd_q[0]) rx_q <= rx_sh_q;
      if (finish) begin
        done_q <= 1'b1;
      end else if (rd_en && (address == A_STATUS)) begin
        done_q <= 1'b0;
      end
    end
  end

  assign readdata = rdata_q;

endmodule

// File: tb/tb_kernel_rtc_ctrl.sv
// tb/tb_kernel_rtc_ctrl.sv - directed self-checking bench for kernel_rtc_ctrl
module tb_kernel_rtc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic [1:0]  address;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  wire  [31:0] readdata;
  wire         rtc_ce;
  wire         rtc_sclk;
  wire         rtc_io;

  logic probe_en  = 1'b0;
  logic probe_val = 1'b0;
  logic drv_en    = 1'b0;
  logic drv_val   = 1'b0;

  assign rtc_io = drv_en ? drv_val : (probe_en ? probe_val : 1'bz);

  kernel_rtc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .rtc_ce     (rtc_ce),
    .rtc_sclk   (rtc_sclk),
    .rtc_io     (rtc_io)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pin monitor and RTC slave model, evaluated mid-cycle
  int         rise_total = 0;
  int         ce_total   = 0;
  logic       sclk_prev  = 1'b0;
  logic       cap [0:63];
  logic       model_en   = 1'b0;
  int         model_base = 0;
  logic [7:0] model_byte = 8'h3C;
  int         nrise;

  always @(negedge clk) begin
    if (rtc_ce) ce_total <= ce_total + 1;
    if (rtc_sclk && !sclk_prev) begin
      cap[rise_total % 64] <= rtc_io;
      rise_total <= rise_total + 1;
    end
    if (!rtc_sclk && sclk_prev) begin
      nrise = rise_total - model_base;
      if (model_en && nrise >= 8 && nrise < 16) begin
        drv_en  <= 1'b1;
        drv_val <= model_byte[3'(nrise - 8)];
      end else begin
        drv_en <= 1'b0;
      end
    end
    sclk_prev <= rtc_sclk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = a;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    read_n     = 1'b1;
    d = readdata;
  endtask

  task automatic probe(input string tag, input logic v);
    probe_en  = 1'b1;
    probe_val = v;
    #1;
    chk(tag, {31'd0, rtc_io}, {31'd0, v});
    probe_en = 1'b0;
  endtask

  // Watches STATUS without chipselect (so DONE is not cleared) until BUSY drops
  task automatic wait_idle(input int n0, output int len, output logic [31:0] st);
    len = -1;
    st  = 32'd0;
    chipselect = 1'b0;
    address    = 2'd2;
    for (int k = 0; k < 4000 && len < 0; k++) begin
      @(posedge clk);
      #1;
      if (!readdata[0]) begin
        len = cyc - n0 - 1;
        st  = readdata;
      end
    end
  endtask

  task automatic get_bits(input int base, output logic [15:0] v);
    for (int i = 0; i < 16; i++) v[i] = cap[(base + i) % 64];
  endtask

  logic [31:0] rd;
  logic [15:0] bits;
  int          n0;
  int          len;
  int          rbase;
  int          cbase;
  logic        found;

  initial begin
    reset      = 1'b1;
    chipselect = 1'b0;
    address    = 2'd0;
    write_n    = 1'b1;
    read_n     = 1'b1;
    writedata  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce", {31'd0, rtc_ce}, 32'd0);
    chk("rst_sclk", {31'd0, rtc_sclk}, 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    reset = 1'b0;
    probe("rst_io_z0", 1'b0);
    probe("rst_io_z1", 1'b1);
    bus_rd(2'd2, rd); chk("rst_status", rd, 32'd0);
    bus_rd(2'd3, rd); chk("rst_div", rd, 32'd49);
    bus_rd(2'd0, rd); chk("rst_data", rd, 32'd0);
    bus_rd(2'd1, rd); chk("rst_cmd", rd, 32'd0);

    // Write transaction, H = 1
    bus_wr(2'd3, 32'd0);
    bus_wr(2'd0, 32'hA5);
    rbase = rise_total;
    cbase = ce_total;
    bus_wr(2'd1, 32'h80);
    n0 = cyc;
    wait_idle(n0, len, rd);
    chk("wr_len", 32'(len), 32'd35);
    chk("wr_status_done", rd, 32'd2);
    chk("wr_ce_cycles", 32'(ce_total - cbase), 32'd34);
    chk("wr_rises", 32'(rise_total - rbase), 32'd16);
    get_bits(rbase, bits);
    chk("wr_io_bits", {16'd0, bits}, 32'h0000_A580);

    // DONE clear by STATUS reads
    bus_rd(2'd2, rd); chk("done_rd1", rd, 32'd2);
    bus_rd(2'd2, rd); chk("done_rd2", rd, 32'd0);

    // Read transaction, H = 2, slave returns 0x3C
    bus_wr(2'd3, 32'd1);
    model_base = rise_total;
    model_en   = 1'b1;
    rbase = rise_total;
    bus_wr(2'd1, 32'h81);
    n0 = cyc;
    chipselect = 1'b0;
    address    = 2'd2;
    repeat (69) @(posedge clk);
    #1;
    chk("rd_busy_69", readdata, 32'd1);
    bus_rd(2'd2, rd); chk("rd_status_on_done_edge", rd, 32'd1);
    bus_rd(2'd2, rd); chk("rd_done_kept", rd, 32'd2);
    bus_rd(2'd2, rd); chk("rd_done_cleared", rd, 32'd0);
    chk("rd_rises", 32'(rise_total - rbase), 32'd16);
    model_en = 1'b0;
    bus_rd(2'd0, rd); chk("rd_data", rd, 32'h3C);
    bus_rd(2'd1, rd); chk("rd_cmd", rd, 32'h81);

    // Busy lockout, H = 1
    bus_wr(2'd3, 32'd0);
    bus_wr(2'd0, 32'h5A);
    rbase = rise_total;
    cbase = ce_total;
    bus_wr(2'd1, 32'h82);
    n0 = cyc;
    bus_wr(2'd1, 32'h83);
    bus_wr(2'd0, 32'hFF);
    bus_wr(2'd3, 32'd7);
    wait_idle(n0, len, rd);
    chk("lk_len", 32'(len), 32'd35);
    chk("lk_status", rd, 32'd2);
    chk("lk_ce_cycles", 32'(ce_total - cbase), 32'd34);
    get_bits(rbase, bits);
    chk("lk_io_bits", {16'd0, bits}, 32'h0000_5A82);
    bus_rd(2'd3, rd); chk("lk_div", rd, 32'd0);
    bus_rd(2'd1, rd); chk("lk_cmd", rd, 32'h82);
    bus_rd(2'd0, rd); chk("lk_rx_kept", rd, 32'h3C);

    // Reset during DAT_HI of data bit 3
    rbase = rise_total;
    bus_wr(2'd1, 32'h00);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      #1;
      if ((rise_total - rbase) == 12 && rtc_sclk) found = 1'b1;
    end
    chk("rm_found_dat_hi3", {31'd0, found}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rm_ce", {31'd0, rtc_ce}, 32'd0);
    chk("rm_sclk", {31'd0, rtc_sclk}, 32'd0);
    reset = 1'b0;
    probe("rm_io_z0", 1'b0);
    probe("rm_io_z1", 1'b1);
    bus_rd(2'd2, rd); chk("rm_status", rd, 32'd0);
    bus_rd(2'd3, rd); chk("rm_div", rd, 32'd49);
    bus_wr(2'd1, 32'h00);
    n0 = cyc;
    wait_idle(n0, len, rd);
    chk("rm_new_len", 32'(len), 32'd1750);
    chk("rm_new_status", rd, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
